// File: rtl/psum_neuron_accumulator.sv
// ---------------------------------------------------------------------------
// psum_neuron_accumulator
//
// Membrane-potential stage wrapped around the convolution adder. The stored
// potential is offered to the adder as its accumulator operand, and the
// adder's sum is captured back as the new potential. After NUM_PARTIALS sums
// the potential is compared against THRESHOLD. The block then emits a
// spike/potential token downstream and applies a subtractive reset.
// Every channel is a 4-phase bundled-data handshake sampled on clk.
//
// Optional feature: define PSUM_LEAK_EN to subtract LEAK (saturating at 0)
// from the potential at evaluation time, before the threshold compare.
//
// Ports:
//   clk           in   clock, rising edge
//   reset         in   synchronous active-high reset
//   acc_req       out  request to the adder accumulator operand
//   acc_data      out  current potential, stable while acc_req=1
//   acc_ack       in   adder accumulator acknowledge
//   sum_req       in   adder result request
//   sum_data      in   adder result, valid while sum_req=1
//   sum_ack       out  acknowledge to the adder result
//   out_req       out  request to the downstream collector
//   out_spike     out  1 = spike this timestep
//   out_potential out  residual potential after reset, stable while out_req=1
//   out_ack       in   downstream acknowledge
// ---------------------------------------------------------------------------
module psum_neuron_accumulator #(
    parameter int unsigned WIDTH        = 13,
    parameter int unsigned NUM_PARTIALS = 3,
    parameter int unsigned THRESHOLD    = 100,
    parameter int unsigned LEAK         = 2
) (
    input  logic             clk,
    input  logic             reset,
    output logic             acc_req,
    output logic [WIDTH-1:0] acc_data,
    input  logic             acc_ack,
    input  logic             sum_req,
    input  logic [WIDTH-1:0] sum_data,
    output logic             sum_ack,
    output logic             out_req,
    output logic             out_spike,
    output logic [WIDTH-1:0] out_potential,
    input  logic             out_ack
);

    // The count register must also hold count+1 == NUM_PARTIALS.
    localparam int unsigned      CntW    = $clog2(NUM_PARTIALS + 1);
    localparam logic [CntW-1:0]  CntLast = CntW'(NUM_PARTIALS);
    localparam logic [WIDTH-1:0] Thresh  = WIDTH'(THRESHOLD);

    typedef enum logic [2:0] {
        StAccSend,
        StAccWait,
        StAccRel,
        StSumWait,
        StSumRel,
        StEval,
        StOutWait,
        StOutRel
    } state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] pot_q, pot_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             acc_req_q, acc_req_d;
    logic [WIDTH-1:0] acc_data_q, acc_data_d;
    logic             sum_ack_q, sum_ack_d;
    logic             out_req_q, out_req_d;
    logic             out_spike_q, out_spike_d;
    logic [WIDTH-1:0] out_pot_q, out_pot_d;

    logic [CntW-1:0]  cnt_inc;
    logic             last_partial;
    logic [WIDTH-1:0] eval_pot;
    logic             eval_spike;
    logic [WIDTH-1:0] eval_res;

    assign cnt_inc      = cnt_q + CntW'(1);
    assign last_partial = (cnt_inc == CntLast);

`ifdef PSUM_LEAK_EN
    localparam logic [WIDTH-1:0] LeakAmt = WIDTH'(LEAK);

    // Saturating leak: never wraps below zero.
    assign eval_pot = (pot_q > LeakAmt) ? (pot_q - LeakAmt) : '0;
`else
    assign eval_pot = pot_q;

    // LEAK has no effect in this build.
    if (LEAK != 0) begin : g_leak_unused
    end
`endif

    // The >= guard makes the subtraction underflow-free.
    assign eval_spike = (eval_pot >= Thresh);
    assign eval_res   = eval_spike ? (eval_pot - Thresh) : eval_pot;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StAccSend;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            // Hold off while the adder still has a result up, so that
            // acc_req never overlaps sum_req.
            StAccSend: if (!sum_req) state_d = StAccWait;
            StAccWait: if (acc_ack)  state_d = StAccRel;
            StAccRel:  if (!acc_ack) state_d = StSumWait;
            StSumWait: if (sum_req)  state_d = StSumRel;
            StSumRel: begin
                if (!sum_req) state_d = last_partial ? StEval : StAccSend;
            end
            StEval:    state_d = StOutWait;
            StOutWait: if (out_ack)  state_d = StOutRel;
            StOutRel:  if (!out_ack) state_d = StAccSend;
            default:   state_d = StAccSend;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output / datapath next-state logic (all outputs are registered)
    // -----------------------------------------------------------------------
    always_comb begin
        pot_d       = pot_q;
        cnt_d       = cnt_q;
        acc_req_d   = acc_req_q;
        acc_data_d  = acc_data_q;
        sum_ack_d   = sum_ack_q;
        out_req_d   = out_req_q;
        out_spike_d = out_spike_q;
        out_pot_d   = out_pot_q;
        unique case (state_q)
            StAccSend: begin
                if (!sum_req) begin
                    acc_req_d  = 1'b1;
                    acc_data_d = pot_q;
                end
            end
            StAccWait: if (acc_ack) acc_req_d = 1'b0;
            StAccRel: ;
            StSumWait: begin
                if (sum_req) begin
                    pot_d     = sum_data;
                    sum_ack_d = 1'b1;
                end
            end
            StSumRel: begin
                if (!sum_req) begin
                    sum_ack_d = 1'b0;
                    cnt_d     = last_partial ? '0 : cnt_inc;
                end
            end
            StEval: begin
                pot_d       = eval_res;
                out_spike_d = eval_spike;
                out_pot_d   = eval_res;
                out_req_d   = 1'b1;
            end
            StOutWait: if (out_ack) out_req_d = 1'b0;
            StOutRel: ;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pot_q       <= '0;
            cnt_q       <= '0;
            acc_req_q   <= 1'b0;
            acc_data_q  <= '0;
            sum_ack_q   <= 1'b0;
            out_req_q   <= 1'b0;
            out_spike_q <= 1'b0;
            out_pot_q   <= '0;
        end else begin
            pot_q       <= pot_d;
            cnt_q       <= cnt_d;
            acc_req_q   <= acc_req_d;
            acc_data_q  <= acc_data_d;
            sum_ack_q   <= sum_ack_d;
            out_req_q   <= out_req_d;
            out_spike_q <= out_spike_d;
            out_pot_q   <= out_pot_d;
        end
    end

    assign acc_req       = acc_req_q;
    assign acc_data      = acc_data_q;
    assign sum_ack       = sum_ack_q;
    assign out_req       = out_req_q;
    assign out_spike     = out_spike_q;
    assign out_potential = out_pot_q;

endmodule

// File: tb/tb_psum_neuron_accumulator.sv
// ---------------------------------------------------------------------------
// tb_psum_neuron_accumulator
//
// Scoreboard bench. Stimulus tasks act as the adder and push the expected
// acc_data of every accumulator request and the expected spike/potential
// token into queues. Monitors pop from these queues and compare whenever the
// DUT raises acc_req or out_req. A separate process plays the downstream
// collector. Expected values are hand-computed for NUM_PARTIALS=3 and
// THRESHOLD=100 (and LEAK=2 when PSUM_LEAK_EN is defined).
// ---------------------------------------------------------------------------
module tb_psum_neuron_accumulator;

    localparam int W = 13;

    logic         clk = 1'b0;
    logic         reset;
    logic         acc_req;
    logic [W-1:0] acc_data;
    logic         acc_ack;
    logic         sum_req;
    logic [W-1:0] sum_data;
    logic         sum_ack;
    logic         out_req;
    logic         out_spike;
    logic [W-1:0] out_potential;
    logic         out_ack;

    int n_cmp  = 0;
    int n_fail = 0;
    int ack_delay = 0;

    logic [W-1:0] acc_q[$];
    logic [W:0]   out_q[$];

    psum_neuron_accumulator #(
        .WIDTH        (13),
        .NUM_PARTIALS (3),
        .THRESHOLD    (100),
        .LEAK         (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .acc_req       (acc_req),
        .acc_data      (acc_data),
        .acc_ack       (acc_ack),
        .sum_req       (sum_req),
        .sum_data      (sum_data),
        .sum_ack       (sum_ack),
        .out_req       (out_req),
        .out_spike     (out_spike),
        .out_potential (out_potential),
        .out_ack       (out_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic sig(input int w);
        case (w)
            0:       return acc_req;
            1:       return sum_ack;
            default: return out_req;
        endcase
    endfunction

    // Bounded wait for a DUT output level; a timeout counts as a failure.
    task automatic wait_level(input int w, input logic v, input string nm);
        int n = 0;
        while (sig(w) !== v && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_timeout"}, 32'(sig(w)), 32'(v));
    endtask

    // One adder transaction returning sum s.
    task automatic do_sum(input logic [W-1:0] s);
        wait_level(0, 1'b1, "acc_req_rise");
        @(posedge clk); #1 acc_ack = 1'b1;
        wait_level(0, 1'b0, "acc_req_fall");
        @(posedge clk); #1 acc_ack = 1'b0;
        sum_req  = 1'b1;
        sum_data = s;
        wait_level(1, 1'b1, "sum_ack_rise");
        @(posedge clk); #1 sum_req = 1'b0;
        wait_level(1, 1'b0, "sum_ack_fall");
    endtask

    // One timestep. The accumulator operand of the first sum was pushed by
    // the previous timestep (or at reset); this pushes the rest plus the
    // operand offered at the start of the next timestep.
    task automatic run_timestep(input logic [W-1:0] s1, input logic [W-1:0] s2,
                                input logic [W-1:0] s3, input logic spk,
                                input logic [W-1:0] pot);
        acc_q.push_back(s1);
        acc_q.push_back(s2);
        acc_q.push_back(pot);
        out_q.push_back({spk, pot});
        do_sum(s1);
        do_sum(s2);
        do_sum(s3);
    endtask

    // Accumulator-operand and output-token monitors.
    logic acc_prev = 1'b0;
    logic out_prev = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            if (acc_req && !acc_prev) begin
                if (acc_q.size() == 0) begin
                    check("acc_unexpected", 32'(1), 32'(0));
                end else begin
                    check("acc_data", 32'(acc_data), 32'(acc_q.pop_front()));
                end
            end
            if (out_req && !out_prev) begin
                if (out_q.size() == 0) begin
                    check("out_unexpected", 32'(1), 32'(0));
                end else begin
                    logic [W:0] e;
                    e = out_q.pop_front();
                    check("out_spike", 32'(out_spike), 32'(e[W]));
                    check("out_potential", 32'(out_potential), 32'(e[W-1:0]));
                end
            end
        end
        acc_prev = acc_req;
        out_prev = out_req;
    end

    // Handshakes must never overlap.
    logic sum_req_prev = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            check("one_hot_req", 32'($countones({acc_req, sum_ack, out_req}) > 1), 32'(0));
            if (acc_req && !acc_prev && sum_req_prev) check("acc_over_sum", 32'(1), 32'(0));
        end
        sum_req_prev = sum_req;
    end

    // Downstream collector, with a one-shot acknowledge delay.
    initial begin
        forever begin
            @(negedge clk);
            if (out_req && !reset) begin
                int           d;
                logic         spk;
                logic [W-1:0] pot;
                d   = ack_delay;
                ack_delay = 0;
                spk = out_spike;
                pot = out_potential;
                for (int i = 0; i < d; i++) begin
                    @(negedge clk);
                    check("hold_out_req", 32'(out_req), 32'(1));
                    check("hold_spike", 32'(out_spike), 32'(spk));
                    check("hold_potential", 32'(out_potential), 32'(pot));
                    check("hold_acc_req", 32'(acc_req), 32'(0));
                end
                @(posedge clk); #1 out_ack = 1'b1;
                wait_level(2, 1'b0, "out_req_fall");
                if (d > 0) begin
                    @(negedge clk);
                    check("acc_req_while_ack", 32'(acc_req), 32'(0));
                end
                @(posedge clk); #1 out_ack = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b1;
        acc_ack  = 1'b0;
        sum_req  = 1'b0;
        sum_data = '0;
        out_ack  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_acc_req", 32'(acc_req), 32'(0));
        check("rst_acc_data", 32'(acc_data), 32'(0));
        check("rst_sum_ack", 32'(sum_ack), 32'(0));
        check("rst_out_req", 32'(out_req), 32'(0));
        check("rst_out_spike", 32'(out_spike), 32'(0));
        check("rst_out_potential", 32'(out_potential), 32'(0));

        acc_q.push_back(13'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("first_acc_req", 32'(acc_req), 32'(1));

`ifdef PSUM_LEAK_EN
        run_timestep(13'd14, 13'd19, 13'd137, 1'b1, 13'd35);
        run_timestep(13'd5, 13'd50, 13'd99, 1'b0, 13'd97);
        ack_delay = 10;
        run_timestep(13'd3, 13'd4, 13'd100, 1'b0, 13'd98);
`else
        run_timestep(13'd14, 13'd19, 13'd137, 1'b1, 13'd37);
        run_timestep(13'd5, 13'd50, 13'd99, 1'b0, 13'd99);
        ack_delay = 10;
        run_timestep(13'd3, 13'd4, 13'd100, 1'b1, 13'd0);
`endif

        // Reset in SUM_REL with sum_ack high; partial sums are discarded.
        acc_q.push_back(13'd20);
        do_sum(13'd20);
        wait_level(0, 1'b1, "acc_req_rise");
        @(posedge clk); #1 acc_ack = 1'b1;
        wait_level(0, 1'b0, "acc_req_fall");
        @(posedge clk); #1 acc_ack = 1'b0;
        sum_req  = 1'b1;
        sum_data = 13'd30;
        wait_level(1, 1'b1, "sum_ack_rise");
        @(posedge clk); #1 reset = 1'b1;
        sum_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_acc_req", 32'(acc_req), 32'(0));
        check("mid_rst_acc_data", 32'(acc_data), 32'(0));
        check("mid_rst_sum_ack", 32'(sum_ack), 32'(0));
        check("mid_rst_out_req", 32'(out_req), 32'(0));
        check("mid_rst_out_spike", 32'(out_spike), 32'(0));
        check("mid_rst_out_potential", 32'(out_potential), 32'(0));
        acc_q.push_back(13'd0);
        @(posedge clk); #1 reset = 1'b0;

`ifdef PSUM_LEAK_EN
        run_timestep(13'd1, 13'd2, 13'd250, 1'b1, 13'd148);
        run_timestep(13'd10, 13'd20, 13'd101, 1'b0, 13'd99);
        run_timestep(13'd1, 13'd1, 13'd1, 1'b0, 13'd0);
`else
        run_timestep(13'd1, 13'd2, 13'd250, 1'b1, 13'd150);
`endif

        // Let the final token and the next accumulator request drain.
        wait_level(0, 1'b1, "final_acc_req");
        repeat (3) @(negedge clk);
        check("acc_queue_drained", 32'(acc_q.size()), 32'(0));
        check("out_queue_drained", 32'(out_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
